bsg_link_upstream_credit_tx: RTL

Parametrised upstream link transmitter. It accepts full-width core words over a valid/ready handshake and serialises each word into beats across `num_channels_p` parallel channels. Every beat is gated by a local credit counter, which is replenished by receiver token pulses. It generalises the fixed 64-bit / 2-channel / 8-bit upstream path to arbitrary width, channel count and credit depth. It adds credit-overflow detection and exposes sent-beat and returned-credit counters for verification. Single clock domain.

---
 rtl/bsg_link_upstream_credit_tx.sv | 110 +++++++++++
 1 files changed

// File: rtl/bsg_link_upstream_credit_tx.sv
// Upstream link transmitter: serialises core words into channel beats, one beat per
// cycle while local credit lasts, with credit replenished by receiver token pulses.
module bsg_link_upstream_credit_tx #(
  parameter int width_p            = 64,
  parameter int channel_width_p    = 8,
  parameter int num_channels_p     = 2,
  parameter int credits_p          = 16,
  parameter int token_decimation_p = 8,
  parameter int cnt_width_p        = 7
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       core_valid_i,
  input  logic [width_p-1:0]                         core_data_i,
  output logic                                       core_ready_o,
  output logic                                       io_valid_o,
  output logic [num_channels_p*channel_width_p-1:0]  io_data_o,
  input  logic                                       io_token_i,
  output logic [$clog2(credits_p+1)-1:0]             credit_o,
  output logic [cnt_width_p-1:0]                     sent_cnt_o,
  output logic [cnt_width_p-1:0]                     returned_cnt_o,
  output logic                                       busy_o,
  output logic                                       token_err_o
);

  localparam int b_lp      = num_channels_p * channel_width_p;
  localparam int beats_lp  = width_p / b_lp;
  localparam int cw_lp     = $clog2(credits_p + 1);
  localparam int beat_w_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  logic                   loaded_q, loaded_d;
  logic [width_p-1:0]     shift_q, shift_d;
  logic [beat_w_lp-1:0]   beat_q, beat_d;
  logic [cw_lp-1:0]       credit_q, credit_d;
  logic [cnt_width_p-1:0] sent_q, sent_d;
  logic [cnt_width_p-1:0] ret_q, ret_d;
  logic                   err_q, err_d;

  logic                   send;
  logic                   last;
  logic                   accept;
  logic [cw_lp:0]         credit_sum;

  assign send         = loaded_q & (credit_q != '0);
  assign last         = (beat_q == beat_w_lp'(beats_lp - 1));
  assign core_ready_o = ~loaded_q | (send & last);
  assign accept       = core_valid_i & core_ready_o;

  always_comb begin
    loaded_d = loaded_q;
    shift_d  = shift_q;
    beat_d   = beat_q;
    // A new word may only arrive when idle or on the final beat, so accept overrides the shift.
    if (accept) begin
      shift_d  = core_data_i;
      beat_d   = '0;
      loaded_d = 1'b1;
    end else if (send) begin
      if (last) begin
        loaded_d = 1'b0;
      end else begin
        shift_d = shift_q >> b_lp;
        beat_d  = beat_q + beat_w_lp'(1);
      end
    end
  end

  always_comb begin
    // One spare bit holds the sum so an overflowing token can be detected before clamping.
    credit_sum = {1'b0, credit_q} - (cw_lp+1)'(send)
               + (io_token_i ? (cw_lp+1)'(token_decimation_p) : '0);
    credit_d   = credit_sum[cw_lp-1:0];
    err_d      = err_q;
    if (credit_sum > (cw_lp+1)'(credits_p)) begin
      credit_d = cw_lp'(credits_p);
      err_d    = 1'b1;
    end
    sent_d = sent_q + cnt_width_p'(send);
    ret_d  = ret_q + (io_token_i ? cnt_width_p'(token_decimation_p) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loaded_q <= 1'b0;
      shift_q  <= '0;
      beat_q   <= '0;
      credit_q <= cw_lp'(credits_p);
      sent_q   <= '0;
      ret_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      loaded_q <= loaded_d;
      shift_q  <= shift_d;
      beat_q   <= beat_d;
      credit_q <= credit_d;
      sent_q   <= sent_d;
      ret_q    <= ret_d;
      err_q    <= err_d;
    end
  end

  assign io_valid_o     = send;
  assign io_data_o      = shift_q[b_lp-1:0];
  assign credit_o       = credit_q;
  assign sent_cnt_o     = sent_q;
  assign returned_cnt_o = ret_q;
  assign busy_o         = loaded_q;
  assign token_err_o    = err_q;

endmodule
